// File: rtl/m6809_bus_pkg.sv
// Shared types and constants for the 6809E bus responder.
// Holds the E/Q phase encoding, default timing constants and the open-bus value.
package m6809_bus_pkg;

    // E/Q quadrature phases. P3W is P3 held open while the backend is busy.
    typedef enum logic [2:0] {
        P0  = 3'd0,
        P1  = 3'd1,
        P2  = 3'd2,
        P3  = 3'd3,
        P3W = 3'd4
    } phase_t;

    localparam int         QUARTER_DEF = 2;
    localparam int         TIMEOUT_DEF = 16;
    localparam logic [7:0] OPEN_BUS    = 8'hFF;

    // Address window match: compare only the bits selected by the mask.
    function automatic logic addr_hit(input logic [15:0] a,
                                      input logic [15:0] mask,
                                      input logic [15:0] base);
        return (a & mask) == base;
    endfunction

endpackage

// File: rtl/m6809_eq_gen.sv
// E/Q quadrature clock generator for the 6809E.
// A quarter counter advances a four-phase FSM; the stretch input holds E high
// (phase P3W) at the end of P3 until the bus cycle completes. The q_rise,
// e_rise and e_fall strobes flag the clock edge on which that transition lands.
module m6809_eq_gen
    import m6809_bus_pkg::*;
#(
    parameter int QUARTER = QUARTER_DEF
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   stretch,
    output logic   e,
    output logic   q,
    output phase_t phase,
    output logic   q_rise,
    output logic   e_rise,
    output logic   e_fall
);

    localparam int CW = (QUARTER > 1) ? $clog2(QUARTER) : 1;

    logic [CW-1:0] cnt;
    logic          last;

    assign last   = (cnt == CW'(QUARTER - 1));
    assign q_rise = last && (phase == P0);
    assign e_rise = last && (phase == P1);
    assign e_fall = !stretch && ((last && (phase == P3)) || (phase == P3W));

    // Phase sequencing with registered E/Q; P3W parks the counter at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= P0;
            cnt   <= '0;
            e     <= 1'b0;
            q     <= 1'b0;
        end else if (phase == P3W) begin
            cnt <= '0;
            if (!stretch) begin
                phase <= P0;
                e     <= 1'b0;
                q     <= 1'b0;
            end
        end else if (last) begin
            cnt <= '0;
            case (phase)
                P0: begin
                    phase <= P1;
                    q     <= 1'b1;
                end
                P1: begin
                    phase <= P2;
                    e     <= 1'b1;
                end
                P2: begin
                    phase <= P3;
                    q     <= 1'b0;
                end
                P3: begin
                    if (stretch) begin
                        phase <= P3W;
                    end else begin
                        phase <= P0;
                        e     <= 1'b0;
                    end
                end
                default: begin
                    phase <= P0;
                    e     <= 1'b0;
                    q     <= 1'b0;
                end
            endcase
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/m6809e_bus_responder.sv
// Bus-side responder for a 6809E CPU: generates E/Q, decodes an address window
// and completes selected cycles through a req/ack handshake with a backend.
// A slow backend stretches the cycle by holding E high until it acks.
// Optional macro M6809_BUS_TIMEOUT_EN bounds the wait to TIMEOUT CLKs, after
// which reads return the open-bus value.
module m6809e_bus_responder
    import m6809_bus_pkg::*;
#(
    parameter int          QUARTER   = QUARTER_DEF,
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter logic [15:0] ADDR_MASK = 16'hE000,
    parameter int          TIMEOUT   = TIMEOUT_DEF
) (
    input  logic        CLK,
    input  logic        nRESET,
    output logic        E,
    output logic        Q,
    input  logic [15:0] A,
    input  logic        WE,
    input  logic        BA,
    input  logic [7:0]  D_IN,
    output logic [7:0]  D_OUT,
    output logic        D_OE,
    output logic        SEL,
    output logic        BUS_REQ,
    output logic        BUS_WR,
    output logic [15:0] BUS_ADDR,
    output logic [7:0]  BUS_WDATA,
    input  logic [7:0]  BUS_RDATA,
    input  logic        BUS_ACK
);

    if (QUARTER < 1 || TIMEOUT < 1) begin : g_bad_params
        $error("m6809e_bus_responder: QUARTER and TIMEOUT must be >= 1");
    end

    phase_t phase;
    logic   q_rise;
    logic   e_rise;
    logic   e_fall;
    logic   stretch;
    logic   ack_ok;
    logic   to_hit;
    logic   done;

    // Acks arriving with no request outstanding are ignored.
    assign ack_ok = BUS_ACK && BUS_REQ;
    assign done   = ack_ok || to_hit;

    // A completion landing on the last P3 clock cancels the stretch outright.
    // Once in P3W the FSM waits for BUS_REQ to have dropped, so read data sits
    // on D_OUT a full CLK before E falls.
    assign stretch = BUS_REQ && !(done && (phase == P3));

    m6809_eq_gen #(
        .QUARTER (QUARTER)
    ) u_eq_gen (
        .clk     (CLK),
        .rst_n   (nRESET),
        .stretch (stretch),
        .e       (E),
        .q       (Q),
        .phase   (phase),
        .q_rise  (q_rise),
        .e_rise  (e_rise),
        .e_fall  (e_fall)
    );

`ifdef M6809_BUS_TIMEOUT_EN
    logic [15:0] to_cnt;

    assign to_hit = BUS_REQ && !ack_ok && (to_cnt == 16'(TIMEOUT - 1));

    // Count CLKs elapsed since BUS_REQ rose; idle at zero otherwise.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            to_cnt <= '0;
        end else if (!BUS_REQ) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 16'd1;
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    // Decode on Q rise, request on E rise, complete on ack/timeout, release on E fall.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            SEL       <= 1'b0;
            BUS_REQ   <= 1'b0;
            BUS_WR    <= 1'b0;
            BUS_ADDR  <= '0;
            BUS_WDATA <= '0;
            D_OUT     <= '0;
            D_OE      <= 1'b0;
        end else begin
            if (q_rise) begin
                SEL      <= !BA && addr_hit(A, ADDR_MASK, BASE_ADDR);
                BUS_ADDR <= A;
                BUS_WR   <= WE;
            end
            if (e_rise && SEL) begin
                BUS_REQ   <= 1'b1;
                BUS_WDATA <= D_IN;
            end
            if (ack_ok) begin
                BUS_REQ <= 1'b0;
                if (!BUS_WR) begin
                    D_OUT <= BUS_RDATA;
                    D_OE  <= 1'b1;
                end
            end else if (to_hit) begin
                BUS_REQ <= 1'b0;
                if (!BUS_WR) begin
                    D_OUT <= OPEN_BUS;
                    D_OE  <= 1'b1;
                end
            end
            // E fall ends the CPU cycle; D_OUT keeps its last value.
            if (e_fall) begin
                D_OE <= 1'b0;
                SEL  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_m6809e_bus_responder.sv
// Directed self-checking bench for m6809e_bus_responder (QUARTER=2 defaults).
module tb_m6809e_bus_responder;

    logic        CLK = 1'b0;
    logic        nRESET;
    logic        E, Q;
    logic [15:0] A;
    logic        WE, BA;
    logic [7:0]  D_IN, D_OUT;
    logic        D_OE, SEL, BUS_REQ, BUS_WR;
    logic [15:0] BUS_ADDR;
    logic [7:0]  BUS_WDATA, BUS_RDATA;
    logic        BUS_ACK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic pe = 1'b0, pq = 1'b0;
    bit req_any, doe_any;
    int edge_at[4] = '{default: 0};
    int edge_n[4]  = '{default: 0};

    localparam int QR = 0, ER = 1, QF = 2, EF = 3;

    m6809e_bus_responder dut (
        .CLK(CLK), .nRESET(nRESET), .E(E), .Q(Q), .A(A), .WE(WE), .BA(BA),
        .D_IN(D_IN), .D_OUT(D_OUT), .D_OE(D_OE), .SEL(SEL), .BUS_REQ(BUS_REQ),
        .BUS_WR(BUS_WR), .BUS_ADDR(BUS_ADDR), .BUS_WDATA(BUS_WDATA),
        .BUS_RDATA(BUS_RDATA), .BUS_ACK(BUS_ACK)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // One CLK, then sample 1ns after the edge and log E/Q transitions.
    task automatic step();
        @(posedge CLK);
        #1;
        if (Q && !pq)  begin edge_at[QR] = cyc; edge_n[QR]++; end
        if (E && !pe)  begin edge_at[ER] = cyc; edge_n[ER]++; end
        if (!Q && pq)  begin edge_at[QF] = cyc; edge_n[QF]++; end
        if (!E && pe)  begin edge_at[EF] = cyc; edge_n[EF]++; end
        pe = E;
        pq = Q;
        if (BUS_REQ) req_any = 1;
        if (D_OE) doe_any = 1;
    endtask

    task automatic wait_edge(input int which, input string name, output int at);
        int  n0;
        bit  ok;
        n0 = edge_n[which];
        ok = 0;
        at = -1;
        for (int i = 0; i < 64; i++) begin
            step();
            if (edge_n[which] != n0) begin
                ok = 1;
                at = edge_at[which];
                break;
            end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL %s: edge not seen within 64 cycles", name);
        end
    endtask

    task automatic test_reset();
        checks++; if (E !== 1'b0)          begin errors++; $display("FAIL rst_e: got %b want 0", E); end
        checks++; if (Q !== 1'b0)          begin errors++; $display("FAIL rst_q: got %b want 0", Q); end
        checks++; if (D_OUT !== 8'h00)     begin errors++; $display("FAIL rst_dout: got %h want 00", D_OUT); end
        checks++; if (D_OE !== 1'b0)       begin errors++; $display("FAIL rst_doe: got %b want 0", D_OE); end
        checks++; if (SEL !== 1'b0)        begin errors++; $display("FAIL rst_sel: got %b want 0", SEL); end
        checks++; if (BUS_REQ !== 1'b0)    begin errors++; $display("FAIL rst_req: got %b want 0", BUS_REQ); end
        checks++; if (BUS_WR !== 1'b0)     begin errors++; $display("FAIL rst_wr: got %b want 0", BUS_WR); end
        checks++; if (BUS_ADDR !== 16'h0)  begin errors++; $display("FAIL rst_addr: got %h want 0000", BUS_ADDR); end
        checks++; if (BUS_WDATA !== 8'h0)  begin errors++; $display("FAIL rst_wdata: got %h want 00", BUS_WDATA); end
    endtask

    task automatic test_free_run();
        int qr, er, qf, ef, er2;
        A = 16'h8000; BA = 1'b0; WE = 1'b0;
        req_any = 0;
        wait_edge(QR, "fr_qrise", qr);
        wait_edge(ER, "fr_erise", er);
        wait_edge(QF, "fr_qfall", qf);
        wait_edge(EF, "fr_efall", ef);
        wait_edge(ER, "fr_erise2", er2);
        checks++; if (er - qr !== 2)  begin errors++; $display("FAIL fr_q_lead: got %0d want 2", er - qr); end
        checks++; if (qf - qr !== 4)  begin errors++; $display("FAIL fr_q_high: got %0d want 4", qf - qr); end
        checks++; if (ef - er !== 4)  begin errors++; $display("FAIL fr_e_high: got %0d want 4", ef - er); end
        checks++; if (er2 - er !== 8) begin errors++; $display("FAIL fr_period: got %0d want 8", er2 - er); end
        checks++; if (req_any !== 1'b0) begin errors++; $display("FAIL fr_no_req: got %b want 0", req_any); end
    endtask

    task automatic test_read();
        int t, er, ef;
        wait_edge(EF, "rd_sync", t);
        A = 16'h1234; WE = 1'b0; BA = 1'b0; D_IN = 8'h00;
        wait_edge(QR, "rd_qrise", t);
        checks++; if (SEL !== 1'b1)          begin errors++; $display("FAIL rd_sel: got %b want 1", SEL); end
        checks++; if (BUS_WR !== 1'b0)       begin errors++; $display("FAIL rd_wr: got %b want 0", BUS_WR); end
        checks++; if (BUS_ADDR !== 16'h1234) begin errors++; $display("FAIL rd_addr: got %h want 1234", BUS_ADDR); end
        wait_edge(ER, "rd_erise", er);
        checks++; if (BUS_REQ !== 1'b1)      begin errors++; $display("FAIL rd_req: got %b want 1", BUS_REQ); end
        BUS_ACK = 1'b1; BUS_RDATA = 8'h5A;
        step();
        BUS_ACK = 1'b0; A = 16'h8000;
        checks++; if (BUS_REQ !== 1'b0)   begin errors++; $display("FAIL rd_req_drop: got %b want 0", BUS_REQ); end
        checks++; if (D_OE !== 1'b1)      begin errors++; $display("FAIL rd_doe: got %b want 1", D_OE); end
        checks++; if (D_OUT !== 8'h5A)    begin errors++; $display("FAIL rd_dout: got %h want 5a", D_OUT); end
        checks++; if (E !== 1'b1)         begin errors++; $display("FAIL rd_e_high: got %b want 1", E); end
        wait_edge(EF, "rd_efall", ef);
        checks++; if (ef - er !== 4)      begin errors++; $display("FAIL rd_no_stretch: got %0d want 4", ef - er); end
        checks++; if (D_OE !== 1'b0)      begin errors++; $display("FAIL rd_doe_off: got %b want 0", D_OE); end
        checks++; if (D_OUT !== 8'h5A)    begin errors++; $display("FAIL rd_dout_hold: got %h want 5a", D_OUT); end
        checks++; if (SEL !== 1'b0)       begin errors++; $display("FAIL rd_sel_off: got %b want 0", SEL); end
    endtask

    task automatic test_write();
        int t;
        wait_edge(EF, "wr_sync", t);
        A = 16'h0010; WE = 1'b1; D_IN = 8'hC3;
        doe_any = 0;
        wait_edge(QR, "wr_qrise", t);
        checks++; if (BUS_WR !== 1'b1)       begin errors++; $display("FAIL wr_wr: got %b want 1", BUS_WR); end
        checks++; if (BUS_ADDR !== 16'h0010) begin errors++; $display("FAIL wr_addr: got %h want 0010", BUS_ADDR); end
        wait_edge(ER, "wr_erise", t);
        checks++; if (BUS_REQ !== 1'b1)      begin errors++; $display("FAIL wr_req: got %b want 1", BUS_REQ); end
        checks++; if (BUS_WDATA !== 8'hC3)   begin errors++; $display("FAIL wr_wdata: got %h want c3", BUS_WDATA); end
        BUS_ACK = 1'b1; BUS_RDATA = 8'h99;
        step();
        BUS_ACK = 1'b0; A = 16'h8000; WE = 1'b0;
        checks++; if (BUS_REQ !== 1'b0)      begin errors++; $display("FAIL wr_req_drop: got %b want 0", BUS_REQ); end
        wait_edge(EF, "wr_efall", t);
        checks++; if (D_OUT !== 8'h5A)       begin errors++; $display("FAIL wr_dout_kept: got %h want 5a", D_OUT); end
        checks++; if (doe_any !== 1'b0)      begin errors++; $display("FAIL wr_doe_never: got %b want 0", doe_any); end
    endtask

    task automatic test_slow_read();
        int t, er;
        wait_edge(EF, "sl_sync", t);
        A = 16'h1FFE; WE = 1'b0;
        wait_edge(ER, "sl_erise", er);
        repeat (9) step();
        checks++; if (E !== 1'b1)        begin errors++; $display("FAIL sl_e_held: got %b want 1", E); end
        checks++; if (Q !== 1'b0)        begin errors++; $display("FAIL sl_q_low: got %b want 0", Q); end
        checks++; if (BUS_REQ !== 1'b1)  begin errors++; $display("FAIL sl_req_held: got %b want 1", BUS_REQ); end
        BUS_ACK = 1'b1; BUS_RDATA = 8'hA7;
        step();
        BUS_ACK = 1'b0; A = 16'h8000;
        checks++; if (BUS_REQ !== 1'b0)  begin errors++; $display("FAIL sl_req_drop: got %b want 0", BUS_REQ); end
        checks++; if (D_OE !== 1'b1)     begin errors++; $display("FAIL sl_doe: got %b want 1", D_OE); end
        checks++; if (D_OUT !== 8'hA7)   begin errors++; $display("FAIL sl_dout: got %h want a7", D_OUT); end
        checks++; if (E !== 1'b1)        begin errors++; $display("FAIL sl_e_at_ack: got %b want 1", E); end
        step();
        checks++; if (E !== 1'b0)        begin errors++; $display("FAIL sl_e_fall: got %b want 0", E); end
        checks++; if (cyc - er !== 11)   begin errors++; $display("FAIL sl_e_high_len: got %0d want 11", cyc - er); end
        checks++; if (D_OE !== 1'b0)     begin errors++; $display("FAIL sl_doe_off: got %b want 0", D_OE); end
    endtask

    task automatic test_ack_at_p3_end();
        int t, er;
        wait_edge(EF, "pe_sync", t);
        A = 16'h0040; WE = 1'b0;
        wait_edge(ER, "pe_erise", er);
        repeat (3) step();
        BUS_ACK = 1'b1; BUS_RDATA = 8'h3C;
        step();
        BUS_ACK = 1'b0; A = 16'h8000;
        checks++; if (E !== 1'b0)        begin errors++; $display("FAIL pe_no_stretch: got %b want 0", E); end
        checks++; if (BUS_REQ !== 1'b0)  begin errors++; $display("FAIL pe_req: got %b want 0", BUS_REQ); end
        checks++; if (D_OUT !== 8'h3C)   begin errors++; $display("FAIL pe_dout: got %h want 3c", D_OUT); end
        checks++; if (D_OE !== 1'b0)     begin errors++; $display("FAIL pe_doe: got %b want 0", D_OE); end
    endtask

    task automatic test_unselected();
        logic [15:0] va[2] = '{16'h8000, 16'h0100};
        logic        vb[2] = '{1'b0, 1'b1};
        int t, er, ef;
        for (int k = 0; k < 2; k++) begin
            wait_edge(EF, "un_sync", t);
            A = va[k]; BA = vb[k]; WE = 1'b0;
            req_any = 0; doe_any = 0;
            wait_edge(QR, "un_qrise", t);
            checks++; if (SEL !== 1'b0) begin errors++; $display("FAIL un_sel[%0d]: got %b want 0", k, SEL); end
            BUS_ACK = 1'b1; BUS_RDATA = 8'hEE;
            step();
            BUS_ACK = 1'b0;
            wait_edge(ER, "un_erise", er);
            wait_edge(EF, "un_efall", ef);
            A = 16'h8000; BA = 1'b0;
            checks++; if (ef - er !== 4)     begin errors++; $display("FAIL un_no_stretch[%0d]: got %0d want 4", k, ef - er); end
            checks++; if (req_any !== 1'b0)  begin errors++; $display("FAIL un_no_req[%0d]: got %b want 0", k, req_any); end
            checks++; if (doe_any !== 1'b0)  begin errors++; $display("FAIL un_no_doe[%0d]: got %b want 0", k, doe_any); end
            checks++; if (D_OUT !== 8'h3C)   begin errors++; $display("FAIL un_stray_ack[%0d]: got %h want 3c", k, D_OUT); end
        end
    endtask

`ifdef M6809_BUS_TIMEOUT_EN
    task automatic test_timeout();
        int t, er;
        wait_edge(EF, "to_sync", t);
        A = 16'h0020; WE = 1'b0;
        wait_edge(ER, "to_erise", er);
        A = 16'h8000;
        repeat (15) step();
        checks++; if (BUS_REQ !== 1'b1)  begin errors++; $display("FAIL to_req_15: got %b want 1", BUS_REQ); end
        step();
        checks++; if (BUS_REQ !== 1'b0)  begin errors++; $display("FAIL to_req_16: got %b want 0", BUS_REQ); end
        checks++; if (D_OUT !== 8'hFF)   begin errors++; $display("FAIL to_dout: got %h want ff", D_OUT); end
        checks++; if (D_OE !== 1'b1)     begin errors++; $display("FAIL to_doe: got %b want 1", D_OE); end
        checks++; if (E !== 1'b1)        begin errors++; $display("FAIL to_e_held: got %b want 1", E); end
        step();
        checks++; if (E !== 1'b0)        begin errors++; $display("FAIL to_e_fall: got %b want 0", E); end
    endtask
`endif

    task automatic test_reset_mid_stretch();
        int t, rel, qr;
        wait_edge(EF, "rm_sync", t);
        A = 16'h0030; WE = 1'b0;
        wait_edge(ER, "rm_erise", t);
        A = 16'h8000;
        repeat (6) step();
        checks++; if (E !== 1'b1)        begin errors++; $display("FAIL rm_stretching: got %b want 1", E); end
        nRESET = 1'b0;
        #1;
        checks++; if (E !== 1'b0)        begin errors++; $display("FAIL rm_e: got %b want 0", E); end
        checks++; if (Q !== 1'b0)        begin errors++; $display("FAIL rm_q: got %b want 0", Q); end
        checks++; if (BUS_REQ !== 1'b0)  begin errors++; $display("FAIL rm_req: got %b want 0", BUS_REQ); end
        checks++; if (SEL !== 1'b0)      begin errors++; $display("FAIL rm_sel: got %b want 0", SEL); end
        step();
        step();
        nRESET = 1'b1;
        rel = cyc;
        req_any = 0;
        wait_edge(QR, "rm_qrise", qr);
        checks++; if (qr - rel !== 2)    begin errors++; $display("FAIL rm_restart: got %0d want 2", qr - rel); end
        wait_edge(EF, "rm_efall", t);
        checks++; if (req_any !== 1'b0)  begin errors++; $display("FAIL rm_no_req: got %b want 0", req_any); end
    endtask

    initial begin
        nRESET = 1'b0;
        A = 16'h8000; WE = 1'b0; BA = 1'b0; D_IN = 8'h00;
        BUS_RDATA = 8'h00; BUS_ACK = 1'b0;
        req_any = 0; doe_any = 0;
        repeat (3) step();
        test_reset();
        nRESET = 1'b1;
        test_free_run();
        test_read();
        test_write();
        test_slow_read();
        test_ack_at_p3_end();
        test_unselected();
`ifdef M6809_BUS_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_stretch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/m6809e_bus_responder.md
Name: m6809e_bus_responder

Overview:
- Bus-side counterpart to the MC68A09E CPU wrapper. It generates the E/Q quadrature clocks the 6809E needs, decodes CPU cycles into a selected address window, and completes each selected cycle through a req/ack handshake with a backend (RAM, ROM or I/O model).
- When the backend is slow, it stretches the cycle by holding E high. The CPU therefore always gets valid read data before E falls.

Parameters:
- QUARTER, 2, CLK cycles per E/Q quarter-phase (≥1); E period = 4*QUARTER.
- BASE_ADDR, 16'h0000, window base; match when (A & ADDR_MASK) == BASE_ADDR.
- ADDR_MASK, 16'hE000, address bits compared for selection.
- TIMEOUT, 16, max CLK cycles BUS_REQ may stay high awaiting BUS_ACK (used only with timeout feature).

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- nRESET  in  1  asynchronous, active-low reset.
- E  out  1  6809E E clock.
- Q  out  1  6809E Q clock (leads E by one quarter).
- A  in  16  CPU address.
- WE  in  1  CPU write enable, active high.
- BA  in  1  CPU bus available; high = CPU bus released, cycle ignored.
- D_IN  in  8  CPU write data.
- D_OUT  out  8  read data to CPU.
- D_OE  out  1  D_OUT drive enable.
- SEL  out  1  current cycle hits window.
- BUS_REQ  out  1  backend request, held until ack/timeout.
- BUS_WR  out  1  1 = write, 0 = read; valid with BUS_REQ.
- BUS_ADDR  out  16  registered address; valid with BUS_REQ.
- BUS_WDATA  out  8  registered write data; valid with BUS_REQ.
- BUS_RDATA  in  8  backend read data; valid with BUS_ACK.
- BUS_ACK  in  1  one-CLK completion pulse.

Behaviour:
- Reset values: E=0, Q=0, D_OUT=8'h00, D_OE=0, SEL=0, BUS_REQ=0, BUS_WR=0, BUS_ADDR=0, BUS_WDATA=0, phase=P0, quarter counter=0. Reset mid-cycle aborts everything; no pending request survives.
- Phase FSM, each phase lasts QUARTER CLKs unless stretched:
  - P0: E=0, Q=0.
  - P1: E=0, Q=1.
  - P2: E=1, Q=1.
  - P3: E=1, Q=0.
  - P3W: E=1, Q=0 (stretch).
  - E and Q are registered outputs.
- P0→P1 transition (Q rise): sample A, WE, BA. SEL <= (!BA && (A & ADDR_MASK) == BASE_ADDR); BUS_ADDR <= A; BUS_WR <= WE.
- P1→P2 transition (E rise): if SEL, then BUS_REQ <= 1 and BUS_WDATA <= D_IN (written on reads too, ignored by backend).
- BUS_ACK is sampled only while BUS_REQ=1; an ack while REQ=0 is ignored. On an accepted ack: BUS_REQ <= 0 next cycle; if read, D_OUT <= BUS_RDATA and D_OE <= 1.
- End of P3:
  - If BUS_REQ is still 1, enter P3W instead of P0. E stays high and Q stays low until ack.
  - P3W→P0 on the cycle after the ack is accepted.
  - An ack during P2/P3 causes no stretch.
- E fall (entry to P0): D_OE <= 0, SEL <= 0. D_OUT holds its value.
- Unselected cycles and cycles with BA=1 produce no request and no stretch. D_OE stays 0.
- Request latency: BUS_REQ rises on the same edge E rises. With ack one CLK later and QUARTER≥2, there is never a stretch.
- Simultaneous ack and P3 end: the ack wins; go to P0, no stretch.
- Only one outstanding request exists at any time.

Optional Feature:
- Macro M6809_BUS_TIMEOUT_EN.
- Defined: a counter starts at BUS_REQ rise. If TIMEOUT cycles elapse without ack, BUS_REQ <= 0. For a read, D_OUT <= 8'hFF and D_OE <= 1. The FSM leaves P3W as if acked.
- Undefined: no counter; stretching is unbounded (backend must eventually ack).

Decomposition:
- Package m6809_bus_pkg:
  - phase enum (P0, P1, P2, P3, P3W);
  - default QUARTER/TIMEOUT constants;
  - open-bus value 8'hFF.
- Sub-module m6809_eq_gen: quarter counter plus phase FSM producing E, Q and phase.
  - Has a STRETCH input that holds P3.
  - The responder top handles decode, handshake and data path.

Test Plan:
- Free-run, QUARTER=2, nothing selected → E/Q period 8 CLKs, Q leads E by 2 CLKs, 50% duty, BUS_REQ never rises.
- Read A=16'h1234, ack 1 CLK after REQ with RDATA=8'h5A → SEL=1, BUS_WR=0, D_OUT=8'h5A with D_OE=1 before E falls, no stretch, D_OE=0 after E falls.
- Write A=16'h0010, D_IN=8'hC3 → BUS_WR=1, BUS_ADDR=16'h0010, BUS_WDATA=8'hC3 on E rise; D_OE stays 0.
- Read with ack delayed 10 CLKs → E held high for 10+1−(cycles left in P3); E falls the cycle after ack; data correct.
- A=16'h8000 (outside window), and separately BA=1 with in-window A → no REQ, no stretch, D_OE=0.
- M6809_BUS_TIMEOUT_EN, TIMEOUT=16, no ack → REQ drops after 16 CLKs, D_OUT=8'hFF; nRESET asserted mid-stretch → E=Q=0, REQ=0 immediately, clean restart at P0.
